// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
//
// Shares the single register-file write port among NREQ writeback sources
// (ALU, load unit, multiplier, ...). Each source presents a write request with a
// valid/ready handshake. One source is granted per cycle, combinationally. The
// winning address/data is registered, and the regfile write port is driven one
// cycle later. Arbitration is either round-robin or fixed priority with aging.
// The aging rule stops a low-priority source from starving.
//
// Parameters
//   NREQ      number of requesters (2..8)
//   DW        write data width
//   AW        register address width
//   MAX_WAIT  aging threshold in cycles for fixed-priority mode (>=1)
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   req_valid      per-requester write pending
//   req_addr       packed destination registers, slice i = [i*AW +: AW]
//   req_data       packed write data, slice i = [i*DW +: DW]
//   req_ready      one-hot grant (or zero), transfer when valid & ready
//   rr_mode        1 = round-robin, 0 = fixed priority with aging
//   hold           pipeline freeze, no grants while high
//   RegWrite       registered regfile write enable
//   WriteRegister  registered regfile write address
//   WriteData      registered regfile write data
//   grant_id       registered index of the source behind the current write
// -----------------------------------------------------------------------------
module regfile_wr_arbiter #(
    parameter int NREQ     = 4,
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int MAX_WAIT = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               rr_mode,
    input  logic               hold,
    output logic               RegWrite,
    output logic [AW-1:0]      WriteRegister,
    output logic [DW-1:0]      WriteData,
    output logic [2:0]         grant_id
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_SAT = CW'(MAX_WAIT);
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

    // Arbitration state
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] waitCnt_q [NREQ];
    logic [CW-1:0] waitCnt_d [NREQ];

    // Registered write port
    logic          regWrite_q, regWrite_d;
    logic [AW-1:0] writeReg_q, writeReg_d;
    logic [DW-1:0] writeData_q, writeData_d;
    logic [2:0]    grantId_q, grantId_d;

    // Combinational grant decision
    logic          grantValid;
    logic [PW-1:0] grantIdx;
    logic [AW-1:0] winAddr;
    logic [DW-1:0] winData;

    // Winner selection. Round-robin is split into two lowest-index scans.
    // The first scan covers the indices at or above the pointer. The second
    // scan covers the wrapped-around part, so no modulo arithmetic is needed.
    // Fixed priority first serves any requester whose age has saturated,
    // then falls back to the lowest valid index.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        if (!reset && !hold) begin
            if (rr_mode) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!grantValid && req_valid[i] && (PW'(i) >= ptr_q)) begin
                        grantValid = 1'b1;
                        grantIdx   = PW'(i);
                    end
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (!grantValid && req_valid[i]) begin
                        grantValid = 1'b1;
                        grantIdx   = PW'(i);
                    end
                end
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!grantValid && req_valid[i] && (waitCnt_q[i] == WAIT_SAT)) begin
                        grantValid = 1'b1;
                        grantIdx   = PW'(i);
                    end
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (!grantValid && req_valid[i]) begin
                        grantValid = 1'b1;
                        grantIdx   = PW'(i);
                    end
                end
            end
        end
    end

    // One-hot ready and the winner's address/data mux
    always_comb begin
        req_ready = '0;
        winAddr   = '0;
        winData   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grantValid && (grantIdx == PW'(i))) begin
                req_ready[i] = 1'b1;
                winAddr      = req_addr[i*AW +: AW];
                winData      = req_data[i*DW +: DW];
            end
        end
    end

    // Next-state logic for the pointer, the age counters and the write port.
    // A write to register 0 still completes the handshake. Only the enable
    // is suppressed, so the source is not left waiting forever.
    always_comb begin
        ptr_d       = ptr_q;
        regWrite_d  = 1'b0;
        writeReg_d  = writeReg_q;
        writeData_d = writeData_q;
        grantId_d   = grantId_q;
        for (int i = 0; i < NREQ; i++) begin
            waitCnt_d[i] = waitCnt_q[i];
        end

        if (grantValid) begin
            ptr_d       = (grantIdx == LAST_IDX) ? '0 : grantIdx + PW'(1);
            regWrite_d  = (winAddr != '0);
            writeReg_d  = winAddr;
            writeData_d = winData;
            grantId_d   = 3'(grantIdx);
        end

        if (!hold) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || (grantValid && (grantIdx == PW'(i)))) begin
                    waitCnt_d[i] = '0;
                end else if (waitCnt_q[i] != WAIT_SAT) begin
                    waitCnt_d[i] = waitCnt_q[i] + CW'(1);
                end
            end
        end
    end

    // State registers. Reset clears the write enable immediately, so a write
    // that was in flight is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= '0;
            regWrite_q  <= 1'b0;
            writeReg_q  <= '0;
            writeData_q <= '0;
            grantId_q   <= '0;
            for (int i = 0; i < NREQ; i++) begin
                waitCnt_q[i] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            regWrite_q  <= regWrite_d;
            writeReg_q  <= writeReg_d;
            writeData_q <= writeData_d;
            grantId_q   <= grantId_d;
            for (int i = 0; i < NREQ; i++) begin
                waitCnt_q[i] <= waitCnt_d[i];
            end
        end
    end

    assign RegWrite      = regWrite_q;
    assign WriteRegister = writeReg_q;
    assign WriteData     = writeData_q;
    assign grant_id      = grantId_q;

endmodule
